// File: rtl/io_loader.sv
// Host-side I/O sequencer for the processor: streams input bytes into the data-in window,
// runs the core until it halts or times out, then streams the data-out window back.
module io_loader #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int unsigned DIN_ADDR       = 32'h3E00,
  parameter int unsigned DOUT_ADDR      = 32'h3F00,
  parameter int unsigned MAX_IO_SIZE    = 256,
  parameter int unsigned HALT_PC        = 32'h14,
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  memEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memData,
  output logic [ADDR_WIDTH-1:0] rdAddr,
  input  logic [7:0]            rdData,
  input  logic [31:0]           pc,
  input  logic [31:0]           a0,
  output logic                  cpuReset,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  overflow,
  output logic [31:0]           retCode
);

  localparam int NB_W = $clog2(MAX_IO_SIZE + 1);
  localparam logic [ADDR_WIDTH-1:0] DIN_BASE  = ADDR_WIDTH'(DIN_ADDR);
  localparam logic [ADDR_WIDTH-1:0] DOUT_BASE = ADDR_WIDTH'(DOUT_ADDR);
  localparam logic [NB_W-1:0]       LAST_IDX  = NB_W'(MAX_IO_SIZE - 1);
  localparam logic [NB_W-1:0]       MAX_NB    = NB_W'(MAX_IO_SIZE);
  localparam logic [31:0]           CLAMP_A0  = 32'(MAX_IO_SIZE / 4);
  localparam logic [31:0]           RST_LAST  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0]           TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]           HALT      = 32'(HALT_PC);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CPURST, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q;
  logic [NB_W-1:0] idx_q;
  logic [NB_W-1:0] nbytes_q;
  logic [NB_W-1:0] nbytes_d;
  logic [NB_W-1:0] idx_next_s;
  logic [31:0]     cnt_q;
  logic            cpu_reset_q, busy_q, done_q, timeout_q, overflow_q;
  logic [31:0]     ret_code_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic            out_valid_q, out_last_q, fresh_q;
  logic [7:0]      out_data_q;

  assign in_ready   = (state_q == S_LOAD);
  assign memEn      = in_valid && in_ready;
  assign memAddr    = memEn ? (DIN_BASE + ADDR_WIDTH'(idx_q)) : {ADDR_WIDTH{1'b0}};
  assign memData    = memEn ? {24'd0, in_data} : 32'd0;
  assign idx_next_s = idx_q + {{(NB_W-1){1'b0}}, 1'b1};

  // The read port has one cycle of latency, so the first valid cycle forwards rdData and later cycles hold it.
  assign out_data  = fresh_q ? rdData : out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign rdAddr    = rd_addr_q;
  assign cpuReset  = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign overflow  = overflow_q;
  assign retCode   = ret_code_q;

  always_comb begin
    if (a0 >= CLAMP_A0) begin
      nbytes_d = MAX_NB;
    end else begin
      nbytes_d = {a0[NB_W-3:0], 2'b00};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= {NB_W{1'b0}};
      nbytes_q    <= {NB_W{1'b0}};
      cnt_q       <= 32'd0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
      ret_code_q  <= 32'd0;
      rd_addr_q   <= {ADDR_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'd0;
      fresh_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_LOAD;
            idx_q       <= {NB_W{1'b0}};
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            ret_code_q  <= 32'd0;
            cpu_reset_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            idx_q <= idx_next_s;
            if (in_last) begin
              state_q <= S_CPURST;
              cnt_q   <= 32'd0;
            end else if (idx_q == LAST_IDX) begin
              overflow_q <= 1'b1;
              state_q    <= S_CPURST;
              cnt_q      <= 32'd0;
            end
          end
        end
        S_CPURST: begin
          if (cnt_q == RST_LAST) begin
            state_q     <= S_RUN;
            cnt_q       <= 32'd0;
            cpu_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_RUN: begin
          // Halt is checked first so it wins over a simultaneous timeout.
          if (pc == HALT) begin
            ret_code_q  <= a0;
            cpu_reset_q <= 1'b1;
            nbytes_q    <= nbytes_d;
            idx_q       <= {NB_W{1'b0}};
            rd_addr_q   <= DOUT_BASE;
            if (nbytes_d == {NB_W{1'b0}}) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (cnt_q == TO_LAST) begin
            timeout_q   <= 1'b1;
            cpu_reset_q <= 1'b1;
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_DRAIN: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            fresh_q     <= 1'b1;
            out_last_q  <= (idx_q == (nbytes_q - {{(NB_W-1){1'b0}}, 1'b1}));
          end else begin
            if (fresh_q) begin
              out_data_q <= rdData;
              fresh_q    <= 1'b0;
            end
            if (out_ready) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              if (out_last_q) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                idx_q     <= idx_next_s;
                rd_addr_q <= DOUT_BASE + ADDR_WIDTH'(idx_next_s);
              end
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_loader.sv
// Directed bench for io_loader: table of load/run/drain sessions plus hand-written
// sequences for start-while-busy and reset during RUN.
module tb_io_loader;

  logic        clock, reset, start;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        memEn;
  logic [31:0] memAddr, memData, rdAddr;
  logic [7:0]  rdData;
  logic [31:0] pc, a0;
  logic        cpuReset, out_valid, out_ready, out_last;
  logic [7:0]  out_data;
  logic        busy, done, timeout, overflow;
  logic [31:0] retCode;

  int checks = 0;
  int errors = 0;

  logic [7:0] dout_mem [0:255];
  logic [7:0] tx[$];
  logic [7:0] got[$];

  typedef struct {
    int          n_in;
    bit          use_last;
    bit          halt;
    bit          rnd;
    logic [31:0] a0;
    int          exp_acc;
    bit          exp_ovf;
    int          exp_nb;
    bit          exp_to;
  } vec_t;

  vec_t vecs[8];

  io_loader #(.TIMEOUT_CYCLES(50)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .memEn(memEn), .memAddr(memAddr), .memData(memData),
    .rdAddr(rdAddr), .rdData(rdData), .pc(pc), .a0(a0), .cpuReset(cpuReset),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .timeout(timeout), .overflow(overflow), .retCode(retCode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Main memory read port: data valid the cycle after the address.
  always @(posedge clock) begin
    rdData <= (rdAddr[31:8] == 24'h00003F) ? dout_mem[rdAddr[7:0]] : 8'h00;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] val, input logic [63:0] exp);
    checks++;
    if (val !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, val, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic load(input int n, input bit use_last, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = tx[i];
      in_last  = use_last && (i == n - 1);
      #1;
      if (!in_ready) begin
        check("load refused memEn", {63'd0, memEn}, 64'd0);
        break;
      end
      check("load memEn", {63'd0, memEn}, 64'd1);
      check("load memAddr", {32'd0, memAddr}, 64'h3E00 + 64'(acc));
      check("load memData", {32'd0, memData}, {56'd0, tx[i]});
      acc++;
      @(negedge clock);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(input bit rnd, output int runc, output int nlast, output int lastpos,
                         output int firstc, output int stab);
    bit         hold;
    logic [7:0] pd;
    logic       pl;
    got.delete();
    runc = 0; nlast = 0; lastpos = -1; firstc = -1; stab = 0; hold = 1'b0; pd = 8'h00; pl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done) break;
      if (!cpuReset) runc++;
      if (hold && out_valid && (out_data !== pd || out_last !== pl)) stab++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && firstc < 0) firstc = c;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (out_last) begin
          nlast++;
          lastpos = got.size() - 1;
        end
      end
      hold = out_valid && !out_ready;
      pd   = out_data;
      pl   = out_last;
      @(negedge clock);
    end
    out_ready = 1'b0;
  endtask

  task automatic run_session(input int k, input vec_t v);
    logic [7:0] w8 [0:7];
    int acc, runc, nlast, lastpos, firstc, stab;
    w8 = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    tx.delete();
    for (int i = 0; i < v.n_in; i++) tx.push_back((v.n_in == 8) ? w8[i] : 8'(i * 3 + 1));
    pulse_start();
    check($sformatf("v%0d busy in load", k), {63'd0, busy}, 64'd1);
    load(v.n_in, v.use_last, acc);
    #1;
    check($sformatf("v%0d accepted", k), 64'(acc), 64'(v.exp_acc));
    check($sformatf("v%0d overflow", k), {63'd0, overflow}, {63'd0, v.exp_ovf});
    check($sformatf("v%0d in_ready after load", k), {63'd0, in_ready}, 64'd0);
    check($sformatf("v%0d cpuReset T+1", k), {63'd0, cpuReset}, 64'd1);
    @(negedge clock);
    check($sformatf("v%0d cpuReset T+2", k), {63'd0, cpuReset}, 64'd1);
    @(negedge clock);
    check($sformatf("v%0d cpuReset T+3", k), {63'd0, cpuReset}, 64'd0);
    if (v.halt) begin
      repeat (2) @(negedge clock);
      pc = 32'h14;
      a0 = v.a0;
      @(negedge clock);
      pc = 32'h0;
      if (v.exp_nb > 0) begin
        check($sformatf("v%0d rdAddr H+1", k), {32'd0, rdAddr}, 64'h3F00);
        check($sformatf("v%0d out_valid H+1", k), {63'd0, out_valid}, 64'd0);
      end else begin
        check($sformatf("v%0d done H+1", k), {63'd0, done}, 64'd1);
      end
    end
    collect(v.rnd, runc, nlast, lastpos, firstc, stab);
    check($sformatf("v%0d done", k), {63'd0, done}, 64'd1);
    check($sformatf("v%0d busy", k), {63'd0, busy}, 64'd0);
    check($sformatf("v%0d cpuReset done", k), {63'd0, cpuReset}, 64'd1);
    check($sformatf("v%0d timeout", k), {63'd0, timeout}, {63'd0, v.exp_to});
    check($sformatf("v%0d retCode", k), {32'd0, retCode}, v.halt ? {32'd0, v.a0} : 64'd0);
    check($sformatf("v%0d nbytes", k), 64'(got.size()), 64'(v.exp_nb));
    check($sformatf("v%0d out_last count", k), 64'(nlast), (v.exp_nb > 0) ? 64'd1 : 64'd0);
    check($sformatf("v%0d stability", k), 64'(stab), 64'd0);
    if (v.exp_nb > 0) begin
      check($sformatf("v%0d out_last pos", k), 64'(lastpos), 64'(v.exp_nb - 1));
      check($sformatf("v%0d first out_valid H+2", k), 64'(firstc), 64'd1);
    end
    if (!v.halt) check($sformatf("v%0d run cycles", k), 64'(runc), 64'd50);
    for (int j = 0; j < got.size() && j < v.exp_nb; j++)
      check($sformatf("v%0d byte %0d", k, j), {56'd0, got[j]}, {56'd0, dout_mem[j]});
  endtask

  initial begin
    int viol;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    pc = 32'h0; a0 = 32'h0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) dout_mem[i] = 8'(i * 37 + 11);
    dout_mem[0] = 8'h0C; dout_mem[1] = 8'h00; dout_mem[2] = 8'h00; dout_mem[3] = 8'h00;
    dout_mem[4] = 8'hFF; dout_mem[5] = 8'hFF; dout_mem[6] = 8'hFF; dout_mem[7] = 8'hFF;

    vecs[0] = '{8,   1'b1, 1'b1, 1'b0, 32'd2,          8,   1'b0, 8,   1'b0};
    vecs[1] = '{2,   1'b1, 1'b0, 1'b0, 32'd0,          2,   1'b0, 0,   1'b1};
    vecs[2] = '{300, 1'b0, 1'b1, 1'b0, 32'd3,          256, 1'b1, 12,  1'b0};
    vecs[3] = '{4,   1'b1, 1'b1, 1'b1, 32'd1000,       4,   1'b0, 256, 1'b0};
    vecs[4] = '{3,   1'b1, 1'b1, 1'b0, 32'd0,          3,   1'b0, 0,   1'b0};
    vecs[5] = '{256, 1'b1, 1'b1, 1'b1, 32'd63,         256, 1'b0, 252, 1'b0};
    vecs[6] = '{1,   1'b1, 1'b1, 1'b0, 32'd64,         1,   1'b0, 256, 1'b0};
    vecs[7] = '{5,   1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF,  5,   1'b0, 256, 1'b0};

    repeat (3) @(negedge clock);
    #1;
    check("reset cpuReset", {63'd0, cpuReset}, 64'd1);
    check("reset outputs", {55'd0, busy, done, timeout, overflow, out_valid, out_last, in_ready, memEn, 1'b0},
          64'd0);
    check("reset rdAddr", {32'd0, rdAddr}, 64'd0);
    check("reset retCode", {32'd0, retCode}, 64'd0);
    check("reset out_data", {56'd0, out_data}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    for (int k = 0; k < 8; k++) run_session(k, vecs[k]);

    // start pulse while loading must not restart the session
    pulse_start();
    in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clock);
    in_data = 8'hBB;
    @(negedge clock);
    in_valid = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    #1;
    check("start in LOAD in_ready", {63'd0, in_ready}, 64'd1);
    check("start in LOAD busy", {63'd0, busy}, 64'd1);
    in_valid = 1'b1; in_data = 8'hCC; in_last = 1'b1;
    #1;
    check("start in LOAD memAddr", {32'd0, memAddr}, 64'h3E02);
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clock);
    pc = 32'h14; a0 = 32'd0;
    @(negedge clock);
    pc = 32'h0;
    check("start in LOAD done", {63'd0, done}, 64'd1);

    // reset during RUN abandons the session
    pulse_start();
    in_valid = 1'b1; in_data = 8'h11; in_last = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clock);
    check("pre-reset in RUN", {63'd0, cpuReset}, 64'd0);
    reset = 1'b0;
    #1;
    check("mid reset cpuReset", {63'd0, cpuReset}, 64'd1);
    check("mid reset flags", {59'd0, busy, done, out_valid, in_ready, memEn}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    pc = 32'h14; a0 = 32'd5;
    viol = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (out_valid || busy || done || !cpuReset || rdAddr != 32'h0) viol++;
    end
    check("post reset quiet", 64'(viol), 64'd0);
    pc = 32'h0;
    @(negedge clock);

    run_session(8, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
